// File: rtl/johnson_phase_monitor.sv
// Johnson (twisted-ring) counter consumer: decodes the 4-bit code to phase/one-hot,
// checks successor ordering, acquires lock, counts revolutions and flags corruption.
module johnson_phase_monitor #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned REV_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       jc_i,
  input  logic             clr_err_i,
  output logic [2:0]       phase_o,
  output logic [7:0]       onehot_o,
  output logic             legal_o,
  output logic             locked_o,
  output logic             err_pulse_o,
  output logic             err_sticky_o,
  output logic [REV_W-1:0] rev_cnt_o
);

  localparam int unsigned      GOOD_W   = $clog2(LOCK_CNT + 1);
  localparam logic [GOOD_W-1:0] LOCK_TGT = GOOD_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCKED,
    FAULT
  } state_e;

  state_e            state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [2:0]        phase_q, phase_d;
  logic [7:0]        onehot_q, onehot_d;
  logic              legal_q, legal_d;
  logic              locked_q;
  logic              err_pulse_q, err_pulse_d;
  logic              err_sticky_q, err_sticky_d;
  logic [REV_W-1:0]  rev_q, rev_d;

  logic              jc_legal;
  logic [2:0]        jc_phase;
  logic [2:0]        phase_next;
  logic [GOOD_W-1:0] good_inc;
  logic              succ;
  logic              wrap;
  logic              fault;

  // jc_i[3] is the first ring stage, so ones fill from the MSB side first.
  always_comb begin
    jc_legal = 1'b1;
    jc_phase = 3'd0;
    case (jc_i)
      4'b0000: jc_phase = 3'd0;
      4'b1000: jc_phase = 3'd1;
      4'b1100: jc_phase = 3'd2;
      4'b1110: jc_phase = 3'd3;
      4'b1111: jc_phase = 3'd4;
      4'b0111: jc_phase = 3'd5;
      4'b0011: jc_phase = 3'd6;
      4'b0001: jc_phase = 3'd7;
      default: jc_legal = 1'b0;
    endcase
  end

  assign phase_next = phase_q + 3'd1;
  assign good_inc   = good_q + GOOD_W'(1);
  assign succ       = jc_legal && (jc_phase == phase_next);
  assign wrap       = (phase_q == 3'd7);
  assign fault      = (state_q == LOCKED) && !succ;

  always_comb begin
    state_d      = state_q;
    good_d       = good_q;
    rev_d        = rev_q;
    err_pulse_d  = 1'b0;
    err_sticky_d = err_sticky_q;
    legal_d      = jc_legal;
    phase_d      = jc_legal ? jc_phase : phase_q;
    onehot_d     = jc_legal ? (8'd1 << jc_phase) : 8'd0;

    case (state_q)
      IDLE: begin
        if (jc_legal) begin
          state_d = ACQ;
          good_d  = '0;
        end
      end
      ACQ: begin
        if (succ) begin
          if (good_inc == LOCK_TGT) begin
            state_d = LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_inc;
          end
        end else if (jc_legal) begin
          good_d = '0;
        end else begin
          state_d = IDLE;
          good_d  = '0;
        end
      end
      LOCKED: begin
        if (succ) begin
          if (wrap) begin
            rev_d = rev_q + REV_W'(1);
          end
        end else begin
          state_d     = FAULT;
          err_pulse_d = 1'b1;
        end
      end
      FAULT: begin
        if (clr_err_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        good_d  = '0;
      end
    endcase

    // A fault in the same cycle as a clear must still leave the flag set.
    if (fault) begin
      err_sticky_d = 1'b1;
    end else if (clr_err_i) begin
      err_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      good_q       <= '0;
      phase_q      <= 3'd0;
      onehot_q     <= 8'd0;
      legal_q      <= 1'b0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      rev_q        <= '0;
    end else begin
      state_q      <= state_d;
      good_q       <= good_d;
      phase_q      <= phase_d;
      onehot_q     <= onehot_d;
      legal_q      <= legal_d;
      locked_q     <= (state_d == LOCKED);
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      rev_q        <= rev_d;
    end
  end

  assign phase_o      = phase_q;
  assign onehot_o     = onehot_q;
  assign legal_o      = legal_q;
  assign locked_o     = locked_q;
  assign err_pulse_o  = err_pulse_q;
  assign err_sticky_o = err_sticky_q;
  assign rev_cnt_o    = rev_q;

endmodule
